// File: rtl/lock_calc_pipe.sv
// Pipelined lock calculator: weighted "for"/"against" scores from one histogram frame per cycle,
// per-frame pass/fail decision and a hysteresis-filtered lock flag.
//
// state      | meaning
// -----------+--------------------------------------------------------
// UNLOCKED   | no lock; waiting for the first passing frame
// ACQUIRE    | counting consecutive passing frames towards LOCK_CNT
// LOCKED     | lock declared; lock_o = 1
// RELEASE    | still locked; counting consecutive failing frames towards UNLOCK_CNT
module lock_calc_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int BIN_NUM    = 32,
    parameter int COEF_WIDTH = 4,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 8,
    localparam int L         = $clog2(BIN_NUM)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_val_i,
    input  logic [L-1:0]                  max_num_i,
    input  logic [DATA_WIDTH*BIN_NUM-1:0] data_i,
    input  logic [COEF_WIDTH-1:0]         max_coef_i,
    input  logic [COEF_WIDTH-1:0]         in_coef_i,
    input  logic [COEF_WIDTH-1:0]         out_coef_i,
    output logic                          val_o,
    output logic                          pass_o,
    output logic                          lock_o,
    output logic [1:0]                    state_o
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam int TW      = DATA_WIDTH + L;
    localparam int CLW     = DATA_WIDTH + 1;
    localparam int PMW     = DATA_WIDTH + COEF_WIDTH;
    localparam int PCW     = CLW + COEF_WIDTH;
    localparam int PW      = DATA_WIDTH + L + COEF_WIDTH + 1;
    localparam int BW      = PMW + PCW + DATA_WIDTH + CLW + COEF_WIDTH;
    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_TC = CNT_W'(UNLOCK_CNT);

    // vld_q[k] flags a frame currently held in stage k
    logic [L+1:0] vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[L:0], data_val_i};
        end
    end

    logic [L-1:0]            m0_q;
    logic [COEF_WIDTH-1:0]   mc0_q, ic0_q, oc0_q;

    always_ff @(posedge clk) begin
        if (data_val_i) begin
            m0_q  <= max_num_i;
            mc0_q <= max_coef_i;
            ic0_q <= in_coef_i;
            oc0_q <= out_coef_i;
        end
    end

    // Level 0 is the registered frame; each further level halves the node count and adds one bit
    for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
        logic [(BIN_NUM >> lv)*(DATA_WIDTH+lv)-1:0] sum_q;

        if (lv == 0) begin : g_in
            always_ff @(posedge clk) begin
                if (data_val_i) begin
                    sum_q <= data_i;
                end
            end
        end else begin : g_add
            always_ff @(posedge clk) begin
                for (int k = 0; k < (BIN_NUM >> lv); k++) begin
                    sum_q[k*(DATA_WIDTH+lv) +: DATA_WIDTH+lv] <=
                        {1'b0, g_lvl[lv-1].sum_q[(2*k)*(DATA_WIDTH+lv-1) +: DATA_WIDTH+lv-1]} +
                        {1'b0, g_lvl[lv-1].sum_q[(2*k+1)*(DATA_WIDTH+lv-1) +: DATA_WIDTH+lv-1]};
                end
            end
        end
    end

    logic [L-1:0]            lo_idx, hi_idx;
    logic [DATA_WIDTH-1:0]   lo_bin, hi_bin, max_c;
    logic [CLW-1:0]          close_c;

    // Edge bins have only one neighbour; the wrapped index is masked off
    always_comb begin
        lo_idx  = m0_q - 1'b1;
        hi_idx  = m0_q + 1'b1;
        max_c   = g_lvl[0].sum_q[m0_q*DATA_WIDTH +: DATA_WIDTH];
        lo_bin  = (m0_q == '0) ? '0 : g_lvl[0].sum_q[lo_idx*DATA_WIDTH +: DATA_WIDTH];
        hi_bin  = (m0_q == L'(BIN_NUM-1)) ? '0 : g_lvl[0].sum_q[hi_idx*DATA_WIDTH +: DATA_WIDTH];
        close_c = {1'b0, lo_bin} + {1'b0, hi_bin};
    end

    logic [DATA_WIDTH-1:0]   max1_q;
    logic [CLW-1:0]          close1_q;
    logic [COEF_WIDTH-1:0]   mc1_q, ic1_q, oc1_q;
    logic [BW-1:0]           bundle2_q;

    always_ff @(posedge clk) begin
        max1_q    <= max_c;
        close1_q  <= close_c;
        mc1_q     <= mc0_q;
        ic1_q     <= ic0_q;
        oc1_q     <= oc0_q;
        bundle2_q <= {PMW'(max1_q) * PMW'(mc1_q), PCW'(close1_q) * PCW'(ic1_q),
                      max1_q, close1_q, oc1_q};
    end

    logic [BW-1:0] bundle_l;

    if (L > 2) begin : g_dly
        logic [BW-1:0] dly_q [L-2];

        always_ff @(posedge clk) begin
            dly_q[0] <= bundle2_q;
            for (int i = 1; i < L-2; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end

        assign bundle_l = dly_q[L-3];
    end else begin : g_nodly
        assign bundle_l = bundle2_q;
    end

    logic [PMW-1:0]          pm_l;
    logic [PCW-1:0]          pc_l;
    logic [DATA_WIDTH-1:0]   max_l;
    logic [CLW-1:0]          close_l;
    logic [COEF_WIDTH-1:0]   oc_l;
    logic [TW-1:0]           total_l, rest_c;
    logic [PW-1:0]           pin_q, pout_q;

    assign {pm_l, pc_l, max_l, close_l, oc_l} = bundle_l;
    assign total_l = g_lvl[L].sum_q;
    // max and close are disjoint bins of total, so this never underflows
    assign rest_c  = total_l - TW'(max_l) - TW'(close_l);

    always_ff @(posedge clk) begin
        pin_q  <= PW'(pm_l) + PW'(pc_l);
        pout_q <= PW'(rest_c) * PW'(oc_l);
    end

    logic              pass_c;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              val_q, pass_q;

    assign pass_c  = (pin_q >= pout_q);
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (pass_c) begin
                    if (LOCK_CNT == 1) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_ACQUIRE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_ACQUIRE: begin
                if (!pass_c) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end else if (cnt_inc == LOCK_TC) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            ST_LOCKED: begin
                if (!pass_c) begin
                    if (UNLOCK_CNT == 1) begin
                        state_d = ST_UNLOCKED;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            default: begin
                if (pass_c) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end else if (cnt_inc == UNLOCK_TC) begin
                    state_d = ST_UNLOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q   <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
        end else begin
            val_q <= vld_q[L+1];
            if (vld_q[L+1]) begin
                pass_q  <= pass_c;
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    assign val_o   = val_q;
    assign pass_o  = pass_q;
    assign state_o = state_q;
    assign lock_o  = (state_q == ST_LOCKED) || (state_q == ST_RELEASE);

endmodule
